wb_arbiter: RTL

//  Shares the single regfile write port between NSRC writeback sources (ALU pipe, load unit, mul/div).
//  - Grants at most one source per cycle and latches it into a one-entry stage register.
//  - The stage register drives the regfile write port.
//  - Forwards the staged value to both regfile read ports, because the regfile updates only at the clock edge.

---
 rtl/hart_pkg.sv | 10 +
 rtl/wb_pick.sv | 27 ++
 rtl/wb_arbiter.sv | 92 +++++++++
 3 files changed

// File: rtl/hart_pkg.sv
// hart_pkg: shared hart-wide widths, writeback request type and register constants
package hart_pkg;
    localparam int XLEN = 64;
    localparam int REG_IDX_W = 5;
    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      d;
    } wb_req_t;
    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/wb_pick.sv
// wb_pick: one-hot grant selection, round-robin from ptr when WB_ARB_RR_EN is defined,
// otherwise fixed priority with the lowest index winning.
module wb_pick #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);
`ifdef WB_ARB_RR_EN
    logic [2*N-1:0] rr, gg;
    logic [N-1:0]   rot, one;
    // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        rr  = {req, req} >> ptr;
        rot = rr[N-1:0];
        one = rot & (-rot);
        gg  = {one, one} << ptr;
        gnt = gg[2*N-1:N];
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;
    assign gnt = req & (-req);
`endif
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: arbitrates NSRC writeback sources onto one regfile write port through a
// one-entry stage with read bypass; WB_ARB_RR_EN selects round-robin over fixed priority.
module wb_arbiter #(
    parameter int NSRC = 2,
    parameter int XLEN = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NSRC-1:0]    src_valid,
    output logic [NSRC-1:0]    src_ready,
    input  logic [5*NSRC-1:0]  src_rd,
    input  logic [XLEN*NSRC-1:0] src_d,
    input  logic               hold,
    output logic               rf_wr,
    output logic [4:0]         rf_rd,
    output logic [XLEN-1:0]    rf_d,
    input  logic [4:0]         rs1,
    input  logic [4:0]         rs2,
    input  logic [XLEN-1:0]    r1_rf,
    input  logic [XLEN-1:0]    r2_rf,
    output logic [XLEN-1:0]    r1,
    output logic [XLEN-1:0]    r2
);
    import hart_pkg::REG_IDX_W;
    import hart_pkg::REG_ZERO;

    localparam int PW = NSRC > 1 ? $clog2(NSRC) : 1;

    logic [NSRC-1:0]      gnt;
    logic [PW-1:0]        ptr;
    logic                 stg_v;
    logic [REG_IDX_W-1:0] stg_rd, g_rd;
    logic [XLEN-1:0]      stg_d, g_d;

    wb_pick #(.N(NSRC), .PW(PW)) u_pick (
        .req(src_valid & {NSRC{~hold}}),
        .ptr(ptr),
        .gnt(gnt)
    );

    assign src_ready = gnt;

    always_comb begin
        g_rd = '0;
        g_d  = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (gnt[i]) begin
                g_rd = src_rd[REG_IDX_W*i +: REG_IDX_W];
                g_d  = src_d[XLEN*i +: XLEN];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_v  <= 1'b0;
            stg_rd <= '0;
            stg_d  <= '0;
        end else begin
            stg_v <= |gnt;
            if (|gnt) begin
                stg_rd <= g_rd;
                stg_d  <= g_d;
            end
        end
    end

`ifdef WB_ARB_RR_EN
    logic [PW-1:0] ptr_nxt;

    always_comb begin
        ptr_nxt = ptr;
        for (int i = 0; i < NSRC; i++) begin
            if (gnt[i]) ptr_nxt = (i == NSRC-1) ? '0 : PW'(i+1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr <= '0;
        else ptr <= ptr_nxt;
    end
`else
    assign ptr = '0;
`endif

    // Writes to x0 are consumed but suppressed, which also keeps them out of the bypass.
    assign rf_wr = stg_v && (stg_rd != REG_ZERO);
    assign rf_rd = stg_rd;
    assign rf_d  = stg_d;
    assign r1    = (rf_wr && rs1 == stg_rd) ? stg_d : r1_rf;
    assign r2    = (rf_wr && rs2 == stg_rd) ? stg_d : r2_rf;
endmodule
